// File: rtl/lcd_queue_aligner_if.sv
// Word-stream read port: a FIFO-style source (data/empty) and the reader
// that pulls from it (rd_en). master = reader side, slave = source side.
interface lcd_queue_aligner_if;
  logic [16:0] data;   // bit 16 = frame-start flag, bits 15:0 = RGB565
  logic        empty;
  logic        rd_en;

  modport master (input data, input empty, output rd_en);
  modport slave  (output data, output empty, input rd_en);
endinterface

// File: rtl/lcd_queue_aligner.sv
// Frame-aligning prefetch stage between the camera FIFO read port and the
// LCD controller. A 2-entry fall-through buffer hides the FIFO read latency;
// an alignment FSM drops words until a flagged frame start and enforces
// exact FRAME_WIDTH*FRAME_HEIGHT frames.
// Optional statistics counters: define LCD_ALIGN_STATS_EN to build
// drop_count/frame_count; otherwise both are tied to zero.
module lcd_queue_aligner #(
  parameter int FRAME_WIDTH  = 480,
  parameter int FRAME_HEIGHT = 272
) (
  input  logic                clk,
  input  logic                reset_n,
  lcd_queue_aligner_if.master fifo,
  lcd_queue_aligner_if.slave  lcd,
  output logic                resync,
  output logic [15:0]         drop_count,
  output logic [15:0]         frame_count
);
  localparam int PIX_TOTAL = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int CW = $clog2(PIX_TOTAL) + 1;
  localparam logic [CW-1:0] PIX_LAST = CW'(PIX_TOTAL);

  typedef enum logic [1:0] {SEEK, STREAM, EXPECT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] pix_cnt, pix_cnt_nxt;
  logic [16:0]   buf_mem [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    occ;
  logic          in_flight;
  logic          flag, pop, push, drop, resync_nxt, frame_done;

  assign flag      = fifo.data[16];
  assign pop       = lcd.rd_en && (occ != 2'd0);
  assign lcd.empty = (occ == 2'd0);
  assign lcd.data  = buf_mem[rd_ptr];

  // Slot reservation: a same-cycle pop frees space, and the word being
  // captured now still needs a slot, so the new read only goes out if the
  // buffer is guaranteed a free entry when its data lands.
  assign fifo.rd_en = !fifo.empty &&
                      ((occ - 2'(pop) + 2'(in_flight)) < 2'd2);

  // Alignment decisions for the word captured this cycle.
  always_comb begin
    state_nxt   = state;
    pix_cnt_nxt = pix_cnt;
    push        = 1'b0;
    drop        = 1'b0;
    resync_nxt  = 1'b0;
    frame_done  = 1'b0;
    if (in_flight) begin
      case (state)
        SEEK: begin
          if (flag) begin
            push        = 1'b1;
            pix_cnt_nxt = CW'(1);
            state_nxt   = STREAM;
          end else begin
            drop = 1'b1;
          end
        end
        STREAM: begin
          push = 1'b1;
          if (flag) begin
            // Early frame start: the short frame is delivered as-is.
            resync_nxt  = 1'b1;
            pix_cnt_nxt = CW'(1);
          end else begin
            pix_cnt_nxt = pix_cnt + CW'(1);
          end
        end
        EXPECT: begin
          if (flag) begin
            push        = 1'b1;
            pix_cnt_nxt = CW'(1);
            state_nxt   = STREAM;
          end else begin
            resync_nxt  = 1'b1;
            drop        = 1'b1;
            pix_cnt_nxt = '0;
            state_nxt   = SEEK;
          end
        end
        default: state_nxt = SEEK;
      endcase
      if (push && pix_cnt_nxt == PIX_LAST) begin
        frame_done = 1'b1;
        state_nxt  = EXPECT;
      end
    end
  end

  // FSM state, pixel counter, resync pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= SEEK;
      pix_cnt <= '0;
      resync  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pix_cnt <= pix_cnt_nxt;
      resync  <= resync_nxt;
    end
  end

  // Read pipeline and 2-entry buffer storage/pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_flight  <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      occ        <= 2'd0;
    end else begin
      in_flight <= fifo.rd_en;
      if (push) begin
        buf_mem[wr_ptr] <= fifo.data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

`ifdef LCD_ALIGN_STATS_EN
  logic [15:0] drop_q, frame_q;

  // Saturating drop counter and wrapping completed-frame counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q  <= '0;
      frame_q <= '0;
    end else begin
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (frame_done) frame_q <= frame_q + 16'd1;
    end
  end

  assign drop_count  = drop_q;
  assign frame_count = frame_q;
`else
  logic unused_stats;
  assign unused_stats = drop ^ frame_done;
  assign drop_count   = '0;
  assign frame_count  = '0;
`endif

endmodule

// File: tb/tb_lcd_queue_aligner.sv
// Randomized self-checking bench for lcd_queue_aligner (4x2 frames).
// A stream-level reference model classifies each word as the FIFO hands it
// out; delivered words are checked in order against the expected queue.
module tb_lcd_queue_aligner;
  localparam int PIX = 8;
`ifdef LCD_ALIGN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        resync;
  logic [15:0] drop_count, frame_count;

  lcd_queue_aligner_if fifo_if ();
  lcd_queue_aligner_if lcd_if ();

  lcd_queue_aligner #(.FRAME_WIDTH(4), .FRAME_HEIGHT(2)) dut (
    .clk(clk), .reset_n(reset_n), .fifo(fifo_if), .lcd(lcd_if),
    .resync(resync), .drop_count(drop_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [16:0] src_q[$];
  logic [16:0] exp_q[$];
  bit   stall = 1'b0;
  bit   rand_ready = 1'b0;
  int   cyc = 0;
  int   issued = 0, consumed = 0, max_occ = 0, dut_resync = 0;
  int   first_rd = -1, first_out = -1, first_pop = -1, last_pop = -1;
  // Reference model: m_pos = -1 while hunting for a flag, else pixels
  // delivered so far in the current frame (PIX = complete, flag due).
  int   m_pos = -1, m_drop = 0, m_frames = 0, m_resync = 0;

  function automatic void model_word(input logic [16:0] w);
    if (w[16]) begin
      if (m_pos > 0 && m_pos < PIX) m_resync++;
      exp_q.push_back(w);
      m_pos = 1;
      if (m_pos == PIX) m_frames++;
    end else if (m_pos < 0) begin
      m_drop++;
    end else if (m_pos == PIX) begin
      m_resync++;
      m_drop++;
      m_pos = -1;
    end else begin
      exp_q.push_back(w);
      m_pos++;
      if (m_pos == PIX) m_frames++;
    end
  endfunction

  function automatic logic [15:0] exp_drop();
    if (!STATS) return 16'h0;
    return (m_drop > 65535) ? 16'hFFFF : 16'(m_drop);
  endfunction

  function automatic logic [15:0] exp_frames();
    return STATS ? 16'(m_frames) : 16'h0;
  endfunction

  // Source FIFO with one-cycle read latency and a registered empty flag.
  always @(posedge clk) begin
    logic [16:0] w;
    cyc <= cyc + 1;
    if (reset_n && fifo_if.rd_en && !fifo_if.empty) begin
      w = src_q.pop_front();
      fifo_if.data <= w;
      issued++;
      model_word(w);
    end
    fifo_if.empty <= stall || (src_q.size() == 0);
  end

  // Downstream reader and in-order scoreboard, sampled on the falling edge.
  initial begin
    lcd_if.rd_en = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        lcd_if.rd_en = 1'b0;
        continue;
      end
      if (resync) dut_resync++;
      if (issued - consumed - m_drop > max_occ) max_occ = issued - consumed - m_drop;
      if (first_rd < 0 && fifo_if.rd_en) first_rd = cyc;
      if (first_out < 0 && !lcd_if.empty) first_out = cyc;
      lcd_if.rd_en = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (lcd_if.rd_en && !lcd_if.empty) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL word: got extra word %h, required none", lcd_if.data);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          if (lcd_if.data !== e) begin
            n_bad++;
            $display("FAIL word #%0d: got %h, required %h", consumed, lcd_if.data, e);
          end
        end
        consumed++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
  end

  task automatic push_frame(input int len, input bit flagged);
    for (int i = 0; i < len; i++)
      src_q.push_back({(flagged && i == 0), 16'($urandom())});
  endtask

  task automatic push_garbage(input int len);
    for (int i = 0; i < len; i++) src_q.push_back({1'b0, 16'($urandom())});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp += 6;
    if (lcd_if.empty !== 1'b1)  begin n_bad++; $display("FAIL rst out_empty: got %b, required 1", lcd_if.empty); end
    if (fifo_if.rd_en !== 1'b0) begin n_bad++; $display("FAIL rst fifo_rd_en: got %b, required 0", fifo_if.rd_en); end
    if (resync !== 1'b0)        begin n_bad++; $display("FAIL rst resync: got %b, required 0", resync); end
    if (lcd_if.data !== 17'h0)  begin n_bad++; $display("FAIL rst out_data: got %h, required 0", lcd_if.data); end
    if (drop_count !== 16'h0)   begin n_bad++; $display("FAIL rst drop_count: got %0d, required 0", drop_count); end
    if (frame_count !== 16'h0)  begin n_bad++; $display("FAIL rst frame_count: got %0d, required 0", frame_count); end
    exp_q.delete();
    m_pos = -1; m_drop = 0; m_frames = 0; m_resync = 0;
    issued = 0; consumed = 0; max_occ = 0; dut_resync = 0;
    first_rd = -1; first_out = -1; first_pop = -1; last_pop = -1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (t >= 3000) begin
      n_bad++;
      $display("FAIL %s drain: %0d src / %0d expected words left, required 0", name, src_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_clean();
    do_reset();
    rand_ready = 1'b0;
    for (int f = 0; f < 3; f++) push_frame(PIX, 1'b1);
    drain("clean");
    n_cmp += 6;
    if (first_out - first_rd !== 2) begin n_bad++; $display("FAIL clean latency: got %0d, required 2", first_out - first_rd); end
    if (last_pop - first_pop !== 23) begin n_bad++; $display("FAIL clean throughput span: got %0d, required 23", last_pop - first_pop); end
    if (consumed !== 24) begin n_bad++; $display("FAIL clean count: got %0d, required 24", consumed); end
    if (dut_resync !== m_resync) begin n_bad++; $display("FAIL clean resync: got %0d, required %0d", dut_resync, m_resync); end
    if (frame_count !== exp_frames()) begin n_bad++; $display("FAIL clean frame_count: got %0d, required %0d", frame_count, exp_frames()); end
    if (drop_count !== exp_drop()) begin n_bad++; $display("FAIL clean drop_count: got %0d, required %0d", drop_count, exp_drop()); end
  endtask

  task automatic test_garbage();
    do_reset();
    push_garbage(5);
    push_frame(PIX, 1'b1);
    drain("garbage");
    n_cmp += 3;
    if (drop_count !== exp_drop()) begin n_bad++; $display("FAIL garbage drop_count: got %0d, required %0d", drop_count, exp_drop()); end
    if (dut_resync !== m_resync) begin n_bad++; $display("FAIL garbage resync: got %0d, required %0d", dut_resync, m_resync); end
    if (consumed !== PIX) begin n_bad++; $display("FAIL garbage count: got %0d, required %0d", consumed, PIX); end
  endtask

  task automatic test_early_flag();
    do_reset();
    push_frame(5, 1'b1);
    push_frame(PIX, 1'b1);
    drain("early");
    n_cmp += 3;
    if (dut_resync !== m_resync) begin n_bad++; $display("FAIL early resync: got %0d, required %0d", dut_resync, m_resync); end
    if (frame_count !== exp_frames()) begin n_bad++; $display("FAIL early frame_count: got %0d, required %0d", frame_count, exp_frames()); end
    if (consumed !== 5 + PIX) begin n_bad++; $display("FAIL early count: got %0d, required %0d", consumed, 5 + PIX); end
  endtask

  task automatic test_missing_flag();
    do_reset();
    push_frame(PIX, 1'b1);
    push_garbage(3);
    push_frame(PIX, 1'b1);
    drain("missing");
    n_cmp += 3;
    if (dut_resync !== m_resync) begin n_bad++; $display("FAIL missing resync: got %0d, required %0d", dut_resync, m_resync); end
    if (drop_count !== exp_drop()) begin n_bad++; $display("FAIL missing drop_count: got %0d, required %0d", drop_count, exp_drop()); end
    if (frame_count !== exp_frames()) begin n_bad++; $display("FAIL missing frame_count: got %0d, required %0d", frame_count, exp_frames()); end
  endtask

  task automatic test_backpressure();
    int t = 0;
    do_reset();
    rand_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      case ($urandom_range(0, 3))
        0: push_frame(int'($urandom_range(2, PIX - 1)), 1'b1);
        1: begin push_garbage(int'($urandom_range(1, 3))); push_frame(PIX, 1'b1); end
        default: push_frame(PIX, 1'b1);
      endcase
    end
    while (issued < 12 && t < 500) begin @(negedge clk); t++; end
    stall = 1'b1;
    repeat (10) @(negedge clk);
    stall = 1'b0;
    drain("backpressure");
    rand_ready = 1'b0;
    n_cmp += 5;
    if (t >= 500) begin n_bad++; $display("FAIL bp issue wait: got %0d issued, required 12", issued); end
    if (max_occ > 2) begin n_bad++; $display("FAIL bp occupancy: got %0d, required <= 2", max_occ); end
    if (dut_resync !== m_resync) begin n_bad++; $display("FAIL bp resync: got %0d, required %0d", dut_resync, m_resync); end
    if (drop_count !== exp_drop()) begin n_bad++; $display("FAIL bp drop_count: got %0d, required %0d", drop_count, exp_drop()); end
    if (frame_count !== exp_frames()) begin n_bad++; $display("FAIL bp frame_count: got %0d, required %0d", frame_count, exp_frames()); end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    do_reset();
    push_frame(PIX, 1'b1);
    while (consumed < 3 && t < 200) begin @(negedge clk); t++; end
    stall = 1'b1;
    repeat (3) @(negedge clk);
    do_reset();
    stall = 1'b0;
    push_frame(PIX, 1'b1);
    drain("reset_mid");
    n_cmp += 4;
    if (t >= 200) begin n_bad++; $display("FAIL rmid wait: got %0d consumed, required 3", consumed); end
    if (consumed !== PIX) begin n_bad++; $display("FAIL rmid count: got %0d, required %0d", consumed, PIX); end
    if (drop_count !== exp_drop()) begin n_bad++; $display("FAIL rmid drop_count: got %0d, required %0d", drop_count, exp_drop()); end
    if (dut_resync !== m_resync) begin n_bad++; $display("FAIL rmid resync: got %0d, required %0d", dut_resync, m_resync); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_garbage();
    test_early_flag();
    test_missing_flag();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
